// File: rtl/abs_value_pkg.sv
// Shared constants and FSM state encoding for the absolute-value datapath.
package abs_value_pkg;

  localparam int unsigned DATA_WIDTH   = 71;
  localparam int unsigned RESULT_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_I = 2'd1,
    SQ_Q = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/serial_squarer.sv
// Shift-add squarer: presents one partial product per step, LSB of the multiplier first.
module serial_squarer #(
  parameter int unsigned WIDTH = 71
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 load,
  input  logic                 step,
  input  logic                 clearAcc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   addend_c,
  output logic                 last
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PROD_W-1:0] mcand;
  logic [WIDTH-1:0]  mplr;
  logic [CNT_W-1:0]  cnt;

  // Load takes priority so the I-to-Q handover can reload on the final I step.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= PROD_W'(operand);
      mplr  <= operand;
      cnt   <= '0;
    end else if (clearAcc) begin
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (step) begin
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign addend_c = mplr[0] ? mcand : '0;
  assign last     = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mag_squared_cal.sv
// Serial I^2 + Q^2 generator; one squarer reused for both operands, summed into one accumulator.
module mag_squared_cal #(
  parameter int unsigned DATA_WIDTH = abs_value_pkg::DATA_WIDTH
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic signed [DATA_WIDTH-1:0]  dataI,
  input  logic signed [DATA_WIDTH-1:0]  dataQ,
  output logic                          outValid,
  output logic [2*DATA_WIDTH-1:0]       dataOut
);

  import abs_value_pkg::*;

  localparam int unsigned OUT_W = 2 * DATA_WIDTH;

  state_t                  state;
  logic [OUT_W-1:0]        acc;
  logic [OUT_W-1:0]        acc_next_c;
  logic [DATA_WIDTH-1:0]   q_abs;
  logic [DATA_WIDTH-1:0]   abs_i_c;
  logic [DATA_WIDTH-1:0]   abs_q_c;
  logic [DATA_WIDTH-1:0]   operand_c;
  logic [OUT_W-1:0]        addend_c;
  logic                    last;
  logic                    transfer_c;
  logic                    load_c;
  logic                    step_c;

  // Magnitude of the most negative code wraps to itself, which is correct as unsigned.
  assign abs_i_c = dataI[DATA_WIDTH-1] ? DATA_WIDTH'($unsigned(-dataI)) : DATA_WIDTH'($unsigned(dataI));
  assign abs_q_c = dataQ[DATA_WIDTH-1] ? DATA_WIDTH'($unsigned(-dataQ)) : DATA_WIDTH'($unsigned(dataQ));

  assign inReady    = (state == IDLE);
  assign transfer_c = inValid && (state == IDLE);
  assign step_c     = (state == SQ_I) || (state == SQ_Q);
  assign load_c     = transfer_c || ((state == SQ_I) && last);
  assign operand_c  = (state == IDLE) ? abs_i_c : q_abs;
  assign acc_next_c = acc + addend_c;

  serial_squarer #(
    .WIDTH (DATA_WIDTH)
  ) u_squarer (
    .clock    (clock),
    .resetN   (resetN),
    .load     (load_c),
    .step     (step_c),
    .clearAcc (transfer_c),
    .operand  (operand_c),
    .addend_c (addend_c),
    .last     (last)
  );

  // Control FSM, accumulator and registered result.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= IDLE;
      acc      <= '0;
      q_abs    <= '0;
      outValid <= 1'b0;
      dataOut  <= '0;
    end else begin
      outValid <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            q_abs <= abs_q_c;
            acc   <= '0;
            state <= SQ_I;
          end
        end
        SQ_I: begin
          acc <= acc_next_c;
          if (last) state <= SQ_Q;
        end
        SQ_Q: begin
          acc <= acc_next_c;
          if (last) begin
            state    <= DONE;
            outValid <= 1'b1;
            dataOut  <= acc_next_c;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_squared_cal.sv
// Directed bench for mag_squared_cal: latency, signs, extremes, back-to-back and reset abort.
module tb_mag_squared_cal;

  localparam int unsigned W   = 71;
  localparam int unsigned OW  = 2 * W;
  localparam int unsigned LAT = 2 * W;

  logic                  clock;
  logic                  resetN;
  logic                  inValid;
  logic                  inReady;
  logic signed [W-1:0]   dataI;
  logic signed [W-1:0]   dataQ;
  logic                  outValid;
  logic [OW-1:0]         dataOut;

  int checks = 0;
  int errors = 0;

  mag_squared_cal #(.DATA_WIDTH(W)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .inValid  (inValid),
    .inReady  (inReady),
    .dataI    (dataI),
    .dataQ    (dataQ),
    .outValid (outValid),
    .dataOut  (dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    dataI = W'({$urandom(), $urandom(), $urandom()});
    dataQ = W'({$urandom(), $urandom(), $urandom()});
  endtask

  // Waits for the result pulse after a transfer edge and checks latency and handshake.
  task automatic wait_result(input string tag, input logic [OW-1:0] exp);
    int lat;
    logic ready_seen;
    lat = 0;
    ready_seen = 1'b0;
    while (!outValid && lat < 400) begin
      tick();
      lat++;
      if (!outValid && inReady) ready_seen = 1'b1;
    end
    chk({tag, "_latency"}, OW'(lat), OW'(LAT));
    chk({tag, "_ready_low"}, OW'(ready_seen), OW'(0));
    chk({tag, "_ready_at_pulse"}, OW'(inReady), OW'(0));
    chk({tag, "_data"}, dataOut, exp);
    tick();
    chk({tag, "_pulse_one_cycle"}, OW'(outValid), OW'(0));
    chk({tag, "_ready_back"}, OW'(inReady), OW'(1));
    chk({tag, "_data_hold"}, dataOut, exp);
  endtask

  task automatic run_pair(input string tag, input logic [W-1:0] i, input logic [W-1:0] q,
                          input logic [OW-1:0] exp);
    dataI = i;
    dataQ = q;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    scramble();
    chk({tag, "_captured"}, OW'(inReady), OW'(0));
    wait_result(tag, exp);
  endtask

  initial begin
    logic [W-1:0]  min_val;
    logic [OW-1:0] big_exp;
    int            quiet;

    resetN  = 1'b0;
    inValid = 1'b0;
    dataI   = '0;
    dataQ   = '0;
    repeat (3) tick();
    chk("reset_ready", OW'(inReady), OW'(1));
    chk("reset_valid", OW'(outValid), OW'(0));
    chk("reset_data", dataOut, OW'(0));
    resetN = 1'b1;
    tick();

    run_pair("p3_4", W'(3), W'(4), OW'(25));
    run_pair("pm3_4", -(W'(3)), W'(4), OW'(25));
    run_pair("p3_m4", W'(3), -(W'(4)), OW'(25));

    min_val = '0;
    min_val[W-1] = 1'b1;
    big_exp = '0;
    big_exp[OW-1] = 1'b1;
    run_pair("min_min", min_val, min_val, big_exp);
    run_pair("zero", W'(0), W'(0), OW'(0));

    // Request held high across two pairs: second capture only once back in IDLE.
    dataI = W'(1);
    dataQ = W'(1);
    inValid = 1'b1;
    tick();
    dataI = W'(5);
    dataQ = W'(12);
    chk("b2b_first_captured", OW'(inReady), OW'(0));
    repeat (LAT - 1) begin
      tick();
      chk("b2b_ignored_busy", OW'(inReady), OW'(0));
    end
    tick();
    chk("b2b_first_pulse", OW'(outValid), OW'(1));
    chk("b2b_first_data", dataOut, OW'(2));
    tick();
    chk("b2b_idle_ready", OW'(inReady), OW'(1));
    tick();
    chk("b2b_second_captured", OW'(inReady), OW'(0));
    inValid = 1'b0;
    scramble();
    wait_result("b2b_second", OW'(169));

    // Reset in the middle of the Q pass discards the partial result.
    dataI = W'(7);
    dataQ = W'(7);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (W + 20) tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    chk("abort_ready", OW'(inReady), OW'(1));
    chk("abort_data", dataOut, OW'(0));
    chk("abort_valid", OW'(outValid), OW'(0));
    quiet = 0;
    repeat (LAT + 10) begin
      tick();
      if (outValid) quiet++;
    end
    chk("abort_no_pulse", OW'(quiet), OW'(0));
    run_pair("after_abort", W'(6), W'(8), OW'(100));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
